pb_tieoff_sink: RTL and testbench

PB_TIEOFF_SINK -- requirements
Module: pb_tieoff_sink

---
 rtl/pb_tieoff_sink_pkg.sv | 60 ++++++
 rtl/pb_sat_counter.sv | 38 +++
 rtl/pb_tieoff_sink.sv | 103 ++++++++++
 tb/tb_pb_tieoff_sink.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pb_tieoff_sink_pkg.sv
// Shared picobello mesh helpers: direction encoding, tie-off predicate and
// neighbour/opposite-direction lookups used when wiring edge routers.
package pb_tieoff_sink_pkg;

    localparam int NumXMesh = 4;
    localparam int NumYMesh = 4;

    typedef enum logic [1:0] {
        DirNorth = 2'd0,
        DirEast  = 2'd1,
        DirSouth = 2'd2,
        DirWest  = 2'd3
    } dir_e;

    // A router port is tied off when it faces outward from the mesh edge.
    function automatic logic is_tied_off(input int x, input int y, input dir_e dir);
        logic tied_s;
        case (dir)
            DirWest:  tied_s = (x == 0);
            DirEast:  tied_s = (x == NumXMesh - 1);
            DirSouth: tied_s = (y == 0);
            DirNorth: tied_s = (y == NumYMesh - 1);
            default:  tied_s = 1'b0;
        endcase
        return tied_s;
    endfunction

    function automatic dir_e opposite_dir(input dir_e dir);
        dir_e opp_s;
        case (dir)
            DirNorth: opp_s = DirSouth;
            DirEast:  opp_s = DirWest;
            DirSouth: opp_s = DirNorth;
            DirWest:  opp_s = DirEast;
            default:  opp_s = DirNorth;
        endcase
        return opp_s;
    endfunction

    function automatic int neighbour_x(input int x, input dir_e dir);
        int nx_s;
        case (dir)
            DirEast: nx_s = x + 1;
            DirWest: nx_s = x - 1;
            default: nx_s = x;
        endcase
        return nx_s;
    endfunction

    function automatic int neighbour_y(input int y, input dir_e dir);
        int ny_s;
        case (dir)
            DirNorth: ny_s = y + 1;
            DirSouth: ny_s = y - 1;
            default:  ny_s = y;
        endcase
        return ny_s;
    endfunction

endpackage

// File: rtl/pb_sat_counter.sv
// Saturating up-counter; clr and inc on the same edge yields a count of one.
module pb_sat_counter #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] cnt
);

    logic [Width-1:0] cnt_r;
    logic [Width-1:0] cnt_s;

    // Next count: clear first, then apply the increment unless already at max.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = inc ? {{(Width-1){1'b0}}, 1'b1} : {Width{1'b0}};
        end else if (inc && (cnt_r != {Width{1'b1}})) begin
            cnt_s = cnt_r + {{(Width-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {Width{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pb_tieoff_sink.sv
// Sink for an outward-facing router port: accepts and drops every flit,
// flags the error and records the destination of the first one dropped.
module pb_tieoff_sink
    import pb_tieoff_sink_pkg::*;
#(
    parameter int FlitWidth  = 64,
    parameter int CoordWidth = 3,
    parameter int DstXLsb    = 0,
    parameter int DstYLsb    = 3,
    parameter int CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [FlitWidth-1:0]  flit_i,
    input  logic                  clr_i,
    output logic                  err_o,
    output logic [CntWidth-1:0]   cnt_o,
    output logic [CoordWidth-1:0] first_x_o,
    output logic [CoordWidth-1:0] first_y_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOGGED = 1'b1
    } state_e;

    state_e                state_r, state_s;
    logic                  ready_r;
    logic                  err_r;
    logic                  capture_s;
    logic                  hs_s;
    logic [CoordWidth-1:0] first_x_r, first_y_r;
    logic                  unused_flit_s;

    assign hs_s = valid_i & ready_r;
    // Only the coordinate fields matter; the rest of the flit is discarded.
    assign unused_flit_s = ^flit_i;

    // Next state: a clear returns to IDLE before the handshake is considered.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        case (clr_i ? IDLE : state_r)
            IDLE: begin
                if (hs_s) begin
                    state_s   = LOGGED;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LOGGED: begin
                state_s = LOGGED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, ready, error flag and first-drop coordinate registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            first_x_r <= {CoordWidth{1'b0}};
            first_y_r <= {CoordWidth{1'b0}};
        end else begin
            state_r <= state_s;
            ready_r <= 1'b1;
            err_r   <= (state_s == LOGGED);
            if (capture_s) begin
                first_x_r <= flit_i[DstXLsb +: CoordWidth];
                first_y_r <= flit_i[DstYLsb +: CoordWidth];
            end else if (clr_i) begin
                first_x_r <= {CoordWidth{1'b0}};
                first_y_r <= {CoordWidth{1'b0}};
            end else begin
                first_x_r <= first_x_r;
                first_y_r <= first_y_r;
            end
        end
    end

    pb_sat_counter #(
        .Width (CntWidth)
    ) u_drop_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr_i),
        .inc (hs_s),
        .cnt (cnt_o)
    );

    assign ready_o   = ready_r;
    assign err_o     = err_r;
    assign first_x_o = first_x_r;
    assign first_y_o = first_y_r;

endmodule

// File: tb/tb_pb_tieoff_sink.sv
// Scoreboard bench for pb_tieoff_sink: a default instance and a CntWidth=4
// instance share stimulus; expected outputs are queued per driven cycle.
module tb_pb_tieoff_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        clr;
    logic [63:0] flit;
    logic        ready, ready4;
    logic        err, err4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic [2:0]  fx, fy, fx4, fy4;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ready;
        logic        err;
        logic [15:0] cnt;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pb_tieoff_sink dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .flit_i(flit), .clr_i(clr), .err_o(err), .cnt_o(cnt),
        .first_x_o(fx), .first_y_o(fy)
    );

    pb_tieoff_sink #(.CntWidth(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready4),
        .flit_i(flit), .clr_i(clr), .err_o(err4), .cnt_o(cnt4),
        .first_x_o(fx4), .first_y_o(fy4)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag, input logic exp_ready);
        chk({tag, ".ready"}, int'(ready), int'(exp_ready));
        chk({tag, ".err"},   int'(err),   0);
        chk({tag, ".cnt"},   int'(cnt),   0);
        chk({tag, ".x"},     int'(fx),    0);
        chk({tag, ".y"},     int'(fy),    0);
        chk({tag, ".cnt4"},  int'(cnt4),  0);
    endtask

    // Drive one cycle at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input logic v, input logic c, input logic [2:0] dx, input logic [2:0] dy,
                        input logic e_err, input int e_cnt, input logic [2:0] e_x,
                        input logic [2:0] e_y, input int e_cnt4);
        exp_t e;
        @(negedge clk);
        valid = v;
        clr   = c;
        flit  = {$urandom, $urandom};
        flit[2:0] = dx;
        flit[5:3] = dy;
        e.ready = 1'b1;
        e.err   = e_err;
        e.cnt   = 16'(e_cnt);
        e.x     = e_x;
        e.y     = e_y;
        e.cnt4  = 4'(e_cnt4);
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", int'(ready),  int'(e.ready));
                chk("err",   int'(err),    int'(e.err));
                chk("cnt",   int'(cnt),    int'(e.cnt));
                chk("x",     int'(fx),     int'(e.x));
                chk("y",     int'(fy),     int'(e.y));
                chk("cnt4",  int'(cnt4),   int'(e.cnt4));
                chk("err4",  int'(err4),   int'(e.err));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        clr   = 1'b0;
        flit  = 64'h0;
        #2;
        chk_all_zero("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after release, then single flit, then back-to-back flits.
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 0, 3'd0, 3'd0, 0);
        step(1'b1, 1'b0, 3'd5, 3'd2, 1'b1, 1, 3'd5, 3'd2, 1);
        step(1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 2, 3'd5, 3'd2, 2);
        step(1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 3, 3'd5, 3'd2, 3);
        // Flit with valid low is ignored.
        step(1'b0, 1'b0, 3'd7, 3'd7, 1'b1, 3, 3'd5, 3'd2, 3);
        // Clear alone, capture, clear with capture, clear alone.
        step(1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 0, 3'd0, 3'd0, 0);
        step(1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 1, 3'd6, 3'd6, 1);
        step(1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 1, 3'd2, 3'd4, 1);
        step(1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 0, 3'd0, 3'd0, 0);

        // Twenty flits: the narrow counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 3'(i), 3'(i + 3), 1'b1, i + 1, 3'd0, 3'd3,
                 (i + 1 > 15) ? 15 : i + 1);
        end

        // Mid-burst reset: asynchronous clear, ready held low through an edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst", 1'b0);
        @(posedge clk);
        #1;
        chk_all_zero("rsthold", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1;
        flit  = 64'h0;
        flit[2:0] = 3'd3;
        flit[5:3] = 3'd3;
        @(posedge clk);
        #1;
        chk_all_zero("release", 1'b1);
        step(1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 1, 3'd4, 3'd4, 1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1, 3'd4, 3'd4, 1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
